// File: rtl/irb_dw_sched.sv
// irb_dw_sched: depthwise-stage beat sequencer for the inverted residual block.
// Ports: start/stride2/n_ox/n_oy config in, busy/done/err status out,
//   addr_valid/addr_ready beat handshake with fmint/kdw/out addresses and acc flags.
module irb_dw_sched #(
  parameter int Nkx    = 3,
  parameter int Nky    = 3,
  parameter int Npar   = 8,
  parameter int Tix_T  = 16,
  parameter int Tiy_T  = 16,
  parameter int Tox_T  = 14,
  parameter int Toy_T  = 14,
  parameter int AW_INT = $clog2(Tix_T*Tiy_T*Npar),
  parameter int AW_KDW = $clog2(Nkx*Nky*Npar),
  parameter int AW_OUT = $clog2(Tox_T*Toy_T*Npar),
  parameter int NOXW   = $clog2(Tox_T+1),
  parameter int NOYW   = $clog2(Toy_T+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stride2,
  input  logic [NOXW-1:0]   n_ox,
  input  logic [NOYW-1:0]   n_oy,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [AW_INT-1:0] fmint_addr,
  output logic [AW_KDW-1:0] kdw_addr,
  output logic              acc_first,
  output logic              acc_last,
  output logic [AW_OUT-1:0] out_addr
);

  localparam int KXW   = (Nkx > 1) ? $clog2(Nkx) : 1;
  localparam int KYW   = (Nky > 1) ? $clog2(Nky) : 1;
  localparam int CW    = (Npar > 1) ? $clog2(Npar) : 1;
  localparam int MAXX2 = (Tix_T - Nkx) / 2 + 1;
  localparam int MAXY2 = (Tiy_T - Nky) / 2 + 1;

  localparam logic [AW_INT-1:0] F_CH  = AW_INT'(Tix_T*Tiy_T);
  localparam logic [AW_INT-1:0] F_ROW = AW_INT'(Tix_T);
  localparam logic [AW_OUT-1:0] O_CH  = AW_OUT'(Tox_T*Toy_T);
  localparam logic [AW_OUT-1:0] O_ROW = AW_OUT'(Tox_T);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_n;

  logic [KXW-1:0]    kx_q, kx_n;
  logic [KYW-1:0]    ky_q, ky_n;
  logic [CW-1:0]     c_q, c_n;
  logic [NOXW-1:0]   ox_q, ox_n;
  logic [NOYW-1:0]   oy_q, oy_n;
  logic              s2_q, s2_n;
  logic [NOXW-1:0]   nox_q, nox_n;
  logic [NOYW-1:0]   noy_q, noy_n;

  // Running address components; summed each beat, never multiplied.
  logic [AW_INT-1:0] fch_q, fch_n;
  logic [AW_INT-1:0] frow_q, frow_n;
  logic [AW_INT-1:0] fky_q, fky_n;
  logic [AW_INT-1:0] fcol_q, fcol_n;
  logic [AW_OUT-1:0] och_q, och_n;
  logic [AW_OUT-1:0] orow_q, orow_n;

  logic [AW_INT-1:0] fmint_q, fmint_n;
  logic [AW_KDW-1:0] kdw_q, kdw_n;
  logic [AW_OUT-1:0] out_q, out_n;

  logic busy_q, busy_n;
  logic done_q, done_n;
  logic err_q, err_n;
  logic valid_q, valid_n;

  logic [NOXW-1:0] maxx;
  logic [NOYW-1:0] maxy;
  logic            legal;
  logic            fire;
  logic            kx_end, ky_end, c_end;
  logic            ox_end, oy_end;
  logic            win_end, grp_end;
  logic            row_end, job_end;
  logic [AW_INT-1:0] fcol_step;
  logic [AW_INT-1:0] frow_step;

  assign maxx  = stride2 ? NOXW'(MAXX2) : NOXW'(Tox_T);
  assign maxy  = stride2 ? NOYW'(MAXY2) : NOYW'(Toy_T);
  assign legal = (n_ox != '0) && (n_ox <= maxx) &&
                 (n_oy != '0) && (n_oy <= maxy);

  assign fire    = (state_q == RUN) && addr_ready;
  assign kx_end  = (kx_q == KXW'(Nkx - 1));
  assign ky_end  = (ky_q == KYW'(Nky - 1));
  assign c_end   = (c_q == CW'(Npar - 1));
  assign ox_end  = (ox_q == nox_q - NOXW'(1));
  assign oy_end  = (oy_q == noy_q - NOYW'(1));
  assign win_end = kx_end && ky_end;
  assign grp_end = win_end && c_end;
  assign row_end = grp_end && ox_end;
  assign job_end = row_end && oy_end;

  assign fcol_step = s2_q ? AW_INT'(2) : AW_INT'(1);
  assign frow_step = s2_q ? AW_INT'(2*Tix_T) : F_ROW;

  always_comb begin
    state_n = state_q;
    kx_n    = kx_q;
    ky_n    = ky_q;
    c_n     = c_q;
    ox_n    = ox_q;
    oy_n    = oy_q;
    s2_n    = s2_q;
    nox_n   = nox_q;
    noy_n   = noy_q;
    fch_n   = fch_q;
    frow_n  = frow_q;
    fky_n   = fky_q;
    fcol_n  = fcol_q;
    och_n   = och_q;
    orow_n  = orow_q;
    kdw_n   = kdw_q;
    busy_n  = busy_q;
    valid_n = valid_q;
    done_n  = 1'b0;
    err_n   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (legal) begin
            state_n = RUN;
            s2_n    = stride2;
            nox_n   = n_ox;
            noy_n   = n_oy;
            kx_n    = '0;
            ky_n    = '0;
            c_n     = '0;
            ox_n    = '0;
            oy_n    = '0;
            fch_n   = '0;
            frow_n  = '0;
            fky_n   = '0;
            fcol_n  = '0;
            och_n   = '0;
            orow_n  = '0;
            kdw_n   = '0;
            busy_n  = 1'b1;
            valid_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      RUN: begin
        if (fire) begin
          kx_n  = kx_end ? '0 : kx_q + KXW'(1);
          // kdw walks 0..Nkx*Nky*Npar-1 once per output pixel.
          kdw_n = grp_end ? '0 : kdw_q + AW_KDW'(1);
          if (kx_end) begin
            ky_n  = ky_end ? '0 : ky_q + KYW'(1);
            fky_n = ky_end ? '0 : fky_q + F_ROW;
          end
          if (win_end) begin
            c_n   = c_end ? '0 : c_q + CW'(1);
            fch_n = c_end ? '0 : fch_q + F_CH;
            och_n = c_end ? '0 : och_q + O_CH;
          end
          if (grp_end) begin
            ox_n   = ox_end ? '0 : ox_q + NOXW'(1);
            fcol_n = ox_end ? '0 : fcol_q + fcol_step;
          end
          if (row_end) begin
            oy_n   = oy_end ? '0 : oy_q + NOYW'(1);
            frow_n = oy_end ? '0 : frow_q + frow_step;
            orow_n = oy_end ? '0 : orow_q + O_ROW;
          end
          if (job_end) begin
            state_n = DONE;
            busy_n  = 1'b0;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    fmint_n = fch_n + frow_n + fky_n + fcol_n + AW_INT'(kx_n);
    out_n   = och_n + orow_n + AW_OUT'(ox_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kx_q    <= '0;
      ky_q    <= '0;
      c_q     <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      s2_q    <= 1'b0;
      nox_q   <= '0;
      noy_q   <= '0;
      fch_q   <= '0;
      frow_q  <= '0;
      fky_q   <= '0;
      fcol_q  <= '0;
      och_q   <= '0;
      orow_q  <= '0;
      fmint_q <= '0;
      kdw_q   <= '0;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_n;
      kx_q    <= kx_n;
      ky_q    <= ky_n;
      c_q     <= c_n;
      ox_q    <= ox_n;
      oy_q    <= oy_n;
      s2_q    <= s2_n;
      nox_q   <= nox_n;
      noy_q   <= noy_n;
      fch_q   <= fch_n;
      frow_q  <= frow_n;
      fky_q   <= fky_n;
      fcol_q  <= fcol_n;
      och_q   <= och_n;
      orow_q  <= orow_n;
      fmint_q <= fmint_n;
      kdw_q   <= kdw_n;
      out_q   <= out_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      err_q   <= err_n;
      valid_q <= valid_n;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign addr_valid = valid_q;
  assign fmint_addr = fmint_q;
  assign kdw_addr   = kdw_q;
  assign out_addr   = out_q;

  // Counters sit at 0 while idle; gate so the flags read 0 off-job.
  assign acc_first = valid_q && (kx_q == '0) && (ky_q == '0);
  assign acc_last  = valid_q && win_end;

endmodule

// File: doc/irb_dw_sched.md
Name: irb_dw_sched

Overview:
Sequencer for the depthwise (DW) stage of the inverted residual block.
- On a start pulse, walks one FMINT tile (Tix_T x Tiy_T x Npar) with the Nkx x Nky DW kernels.
- Each beat carries one FMINT read address, the matching KDW address, and MAC framing flags. The output-pixel address is issued on the last beat of each kernel window.
- Sits between the top-level IRB controller and the FMINT/KDW RAM read ports feeding the DW MAC array.

Parameters:
Nkx, 3, DW kernel width
Nky, 3, DW kernel height
Npar, 8, channels per parallel group (channels per tile pass)
Tix_T, 16, FMINT tile width (row pitch)
Tiy_T, 16, FMINT tile height
Tox_T, 14, max output tile width at stride 1
Toy_T, 14, max output tile height at stride 1
AW_INT, $clog2(Tix_T*Tiy_T*Npar), FMINT address width (11)
AW_KDW, $clog2(Nkx*Nky*Npar), KDW address width (7)
AW_OUT, $clog2(Tox_T*Toy_T*Npar), output address width (11)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE
stride2  in  1  0 = stride 1, 1 = stride 2; latched on start
n_ox  in  $clog2(Tox_T+1)  output tile width; latched on start
n_oy  in  $clog2(Toy_T+1)  output tile height; latched on start
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the final beat handshakes
err  out  1  one-cycle pulse when start carries an illegal config
addr_valid  out  1  beat valid
addr_ready  in  1  consumer accepts beat
fmint_addr  out  AW_INT  c*Tix_T*Tiy_T + (oy*s+ky)*Tix_T + (ox*s+kx)
kdw_addr  out  AW_KDW  c*Nkx*Nky + ky*Nkx + kx
acc_first  out  1  beat is ky=0,kx=0 (clear accumulator)
acc_last  out  1  beat is ky=Nky-1,kx=Nkx-1 (write result)
out_addr  out  AW_OUT  c*Tox_T*Toy_T + oy*Tox_T + ox; meaningful only with acc_last

Behaviour:
- Reset: state IDLE; all counters 0; busy, done, err, addr_valid, acc_first, acc_last = 0; all address outputs 0.
- Stride s is 1 or 2. Legal config: 1 <= n_ox <= MAXX and 1 <= n_oy <= MAXY.
  - Stride 1: MAXX = Tox_T, MAXY = Toy_T.
  - Stride 2: MAXX = (Tix_T-Nkx)/2+1, MAXY = (Tiy_T-Nky)/2+1 (7 with defaults).
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE, start with legal config: latch config, clear counters, go to RUN. busy and addr_valid rise the next cycle, carrying beat 0.
  - IDLE, start with illegal config: err pulses next cycle; stay IDLE; no beats issued.
  - RUN: addr_valid held at 1. Advance only on addr_valid && addr_ready. All outputs stay stable while addr_ready=0.
  - Loop order, innermost first: kx, ky, c, ox, oy. Each counter wraps to 0 and carries into the next.
  - Handshake of the beat with c=Npar-1, ky=Nky-1, kx=Nkx-1, ox=n_ox-1, oy=n_oy-1: addr_valid drops next cycle and the FSM goes to DONE.
  - DONE: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Beat count per job: n_ox*n_oy*Npar*Nkx*Nky. No bubbles while addr_ready stays high (one beat per cycle).
- All outputs are registered. Addresses are built with incremental base registers (row and channel bases); no multipliers in the per-beat path.
- start while busy or in DONE is ignored, with no err.
- rst_n asserted mid-job: immediate return to reset values. The job is abandoned and no done is issued.
- acc_first and acc_last are combinational functions of the registered kx/ky, valid only with addr_valid.

Test Plan:
- Stride 1, n_ox=1, n_oy=1, addr_ready=1 -> 72 consecutive beats; beat 0: fmint 0, kdw 0, acc_first=1; beat 8: fmint 34, kdw 8, acc_last=1, out_addr 0; beat 71: fmint 1826, kdw 71, out_addr 1372; done 1 cycle after beat 71; busy high for exactly 72 cycles.
- Stride 2, n_ox=2, n_oy=1 -> 144 beats; beat 72 (ox=1, c=0, ky=0, kx=0): fmint 2; its acc_last beat: out_addr 1.
- Stride 1, n_ox=1, n_oy=1, addr_ready toggled 1,0,0,1,... -> outputs constant during ready=0; same 72-beat sequence; done only after the final handshake.
- Illegal configs (stride 1 n_ox=15; stride 2 n_oy=8; n_ox=0) -> err pulse, busy stays 0, no addr_valid; a following legal start runs normally.
- start pulsed during RUN -> ignored; beat count unchanged; single done.
- rst_n low at beat 30, then high, then a new start -> all outputs 0 during reset; no done for the aborted job; the new job begins at fmint 0.
